// File: rtl/bcd_pkg.sv
// Shared types for the BCD operand-capture path.
// Digit, 3-digit value and entry-state definitions.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t huns;
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd3_t;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL,
    COMMIT
  } entry_state_e;

  localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/button_debounce.sv
// Pushbutton synchronizer and debouncer.
// Emits a one-cycle registered pulse on each accepted press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press_evt
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic IDLE_LVL = ACTIVE_LOW;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          evt_q, evt_d;
  logic          level;

  assign level     = sync2_q ^ ACTIVE_LOW;
  assign press_evt = evt_q;

  // Count consecutive disagreeing samples; flip stable state on the last one.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    evt_d    = 1'b0;
    if (level != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = level;
        evt_d    = level;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer and debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= IDLE_LVL;
      sync2_q  <= IDLE_LVL;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      evt_q    <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      evt_q    <= evt_d;
    end
  end

endmodule

// File: rtl/bcd_entry_latch.sv
// Calculator-style 3-digit BCD entry with debounced commit.
// Commit shifts current value to y and the entry into x.
module bcd_entry_latch
  import bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter bit ENTER_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       enter_raw,
  input  logic       clear,
  output logic [3:0] cur_ones,
  output logic [3:0] cur_tens,
  output logic [3:0] cur_huns,
  output logic [1:0] digit_count,
  output logic [3:0] x_ones,
  output logic [3:0] x_tens,
  output logic [3:0] x_huns,
  output logic [3:0] y_ones,
  output logic [3:0] y_tens,
  output logic [3:0] y_huns,
  output logic       commit,
  output logic       err
);

  entry_state_e state_q, state_d;
  bcd3_t        cur_q, cur_d;
  bcd3_t        x_q, x_d;
  bcd3_t        y_q, y_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         commit_q, commit_d;
  logic         err_q, err_d;
  logic         press;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ENTER_ACTIVE_LOW)
  ) u_enter_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (enter_raw),
    .press_evt (press)
  );

  // Entry FSM: clear beats press, press beats digit strobe.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    if (clear) begin
      cur_d   = '0;
      cnt_d   = 2'd0;
      state_d = EMPTY;
      err_d   = digit_valid;
    end else if (state_q == COMMIT) begin
      state_d = EMPTY;
      err_d   = digit_valid;
    end else if (press) begin
      y_d      = x_q;
      x_d      = cur_q;
      cur_d    = '0;
      cnt_d    = 2'd0;
      state_d  = COMMIT;
      commit_d = 1'b1;
      err_d    = digit_valid;
    end else if (digit_valid) begin
      if (digit_in > BCD_MAX || state_q == FULL) begin
        err_d = 1'b1;
      end else begin
        cur_d.huns = cur_q.tens;
        cur_d.tens = cur_q.ones;
        cur_d.ones = digit_in;
        cnt_d      = cnt_q + 2'd1;
        state_d    = (cnt_q == 2'd2) ? FULL : PARTIAL;
      end
    end
  end

  // Entry, operand and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      cur_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= 2'd0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
      err_q    <= err_d;
    end
  end

  assign cur_ones    = cur_q.ones;
  assign cur_tens    = cur_q.tens;
  assign cur_huns    = cur_q.huns;
  assign digit_count = cnt_q;
  assign x_ones      = x_q.ones;
  assign x_tens      = x_q.tens;
  assign x_huns      = x_q.huns;
  assign y_ones      = y_q.ones;
  assign y_tens      = y_q.tens;
  assign y_huns      = y_q.huns;
  assign commit      = commit_q;
  assign err         = err_q;

endmodule

// File: tb/tb_bcd_entry_latch.sv
// Directed bench for bcd_entry_latch.
// DEBOUNCE_CYCLES=4, active-low enter button.
module tb_bcd_entry_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       enter_raw;
  logic       clear;
  logic [3:0] cur_ones, cur_tens, cur_huns;
  logic [1:0] digit_count;
  logic [3:0] x_ones, x_tens, x_huns;
  logic [3:0] y_ones, y_tens, y_huns;
  logic       commit;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_entry_latch #(
    .DEBOUNCE_CYCLES  (4),
    .ENTER_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .enter_raw   (enter_raw),
    .clear       (clear),
    .cur_ones    (cur_ones),
    .cur_tens    (cur_tens),
    .cur_huns    (cur_huns),
    .digit_count (digit_count),
    .x_ones      (x_ones),
    .x_tens      (x_tens),
    .x_huns      (x_huns),
    .y_ones      (y_ones),
    .y_tens      (y_tens),
    .y_huns      (y_huns),
    .commit      (commit),
    .err         (err)
  );

  wire [11:0] cur_v = {cur_huns, cur_tens, cur_ones};
  wire [11:0] x_v   = {x_huns, x_tens, x_ones};
  wire [11:0] y_v   = {y_huns, y_tens, y_ones};

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  // Raw low sampled at edge N; commit visible after edge N+6.
  task automatic press_to_commit(input string tag);
    enter_raw = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk({tag, "_early"}, 16'(commit), 16'h0);
    end
    tick();
    chk({tag, "_commit"}, 16'(commit), 16'h1);
  endtask

  task automatic release_btn(input string tag);
    enter_raw = 1'b1;
    tick();
    chk({tag, "_pulse1"}, 16'(commit), 16'h0);
    repeat (8) tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    digit_in    = 4'h0;
    digit_valid = 1'b0;
    enter_raw   = 1'b1;
    clear       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cur", 16'(cur_v), 16'h000);
    chk("rst_cnt", 16'(digit_count), 16'h0);
    chk("rst_x", 16'(x_v), 16'h000);
    chk("rst_y", 16'(y_v), 16'h000);
    chk("rst_commit", 16'(commit), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    #2 rst_n = 1'b1;
    tick();

    // 1: enter 123 and commit
    strobe(4'd1);
    chk("t1_cnt1", 16'(digit_count), 16'h1);
    strobe(4'd2);
    strobe(4'd3);
    chk("t1_cur", 16'(cur_v), 16'h123);
    chk("t1_cnt3", 16'(digit_count), 16'h3);
    press_to_commit("t1");
    chk("t1_x", 16'(x_v), 16'h123);
    chk("t1_y", 16'(y_v), 16'h000);
    chk("t1_cur0", 16'(cur_v), 16'h000);
    chk("t1_cnt0", 16'(digit_count), 16'h0);
    release_btn("t1");

    // 2: two successive commits
    strobe(4'd4);
    strobe(4'd5);
    chk("t2_cur", 16'(cur_v), 16'h045);
    press_to_commit("t2a");
    chk("t2a_x", 16'(x_v), 16'h045);
    chk("t2a_y", 16'(y_v), 16'h123);
    release_btn("t2a");
    strobe(4'd9);
    strobe(4'd9);
    strobe(4'd9);
    press_to_commit("t2b");
    chk("t2b_x", 16'(x_v), 16'h999);
    chk("t2b_y", 16'(y_v), 16'h045);
    release_btn("t2b");

    // 3: bouncing enter never commits
    for (int i = 0; i < 10; i++) begin
      enter_raw = i[0];
      tick();
      chk("t3_bounce", 16'(commit), 16'h0);
      tick();
      chk("t3_bounce", 16'(commit), 16'h0);
    end
    enter_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t3_settle", 16'(commit), 16'h0);
    end
    chk("t3_x", 16'(x_v), 16'h999);
    chk("t3_y", 16'(y_v), 16'h045);

    // 4: rejected strobes
    strobe(4'd3);
    strobe(4'd2);
    strobe(4'd1);
    chk("t4_cur", 16'(cur_v), 16'h321);
    chk("t4_err0", 16'(err), 16'h0);
    strobe(4'hA);
    chk("t4_err_a", 16'(err), 16'h1);
    chk("t4_cur_a", 16'(cur_v), 16'h321);
    tick();
    chk("t4_err_gap", 16'(err), 16'h0);
    strobe(4'd7);
    chk("t4_err_full", 16'(err), 16'h1);
    chk("t4_cur_full", 16'(cur_v), 16'h321);
    chk("t4_cnt", 16'(digit_count), 16'h3);
    tick();
    chk("t4_err_end", 16'(err), 16'h0);

    // 5: clear coincident with press event and digit strobe
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_clr_cur", 16'(cur_v), 16'h000);
    strobe(4'd0);
    strobe(4'd5);
    strobe(4'd6);
    chk("t5_cur", 16'(cur_v), 16'h056);
    chk("t5_cnt3", 16'(digit_count), 16'h3);
    enter_raw = 1'b0;
    tick();
    repeat (5) tick();
    clear       = 1'b1;
    digit_valid = 1'b1;
    digit_in    = 4'd4;
    tick();
    clear       = 1'b0;
    digit_valid = 1'b0;
    chk("t5_commit", 16'(commit), 16'h0);
    chk("t5_cur0", 16'(cur_v), 16'h000);
    chk("t5_cnt0", 16'(digit_count), 16'h0);
    chk("t5_err", 16'(err), 16'h1);
    chk("t5_x", 16'(x_v), 16'h999);
    chk("t5_y", 16'(y_v), 16'h045);
    enter_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t5_after", 16'(commit), 16'h0);
    end

    // 6: async reset mid-entry and mid-debounce
    strobe(4'd1);
    strobe(4'd2);
    chk("t6_cnt2", 16'(digit_count), 16'h2);
    enter_raw = 1'b0;
    tick();
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_cur", 16'(cur_v), 16'h000);
    chk("t6_cnt", 16'(digit_count), 16'h0);
    chk("t6_x", 16'(x_v), 16'h000);
    chk("t6_y", 16'(y_v), 16'h000);
    chk("t6_commit", 16'(commit), 16'h0);
    enter_raw = 1'b1;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t6_nocommit", 16'(commit), 16'h0);
    end
    chk("t6_x_end", 16'(x_v), 16'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
